// File: rtl/udma_i2s_tx_pkg.sv
// Shared types and constants for the uDMA I2S transmit serializer.
package udma_i2s_tx_pkg;

  localparam int unsigned MAX_BITS_WORD = 32;
  localparam int unsigned BIT_CNT_W     = $clog2(MAX_BITS_WORD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Position inside the slot word of the bit driven at step bit_cnt.
  function automatic logic [BIT_CNT_W-1:0] slot_bit_idx(
    input logic                 lsb_first,
    input logic [BIT_CNT_W-1:0] last_idx,
    input logic [BIT_CNT_W-1:0] bit_cnt
  );
    return lsb_first ? bit_cnt : (last_idx - bit_cnt);
  endfunction

endpackage

// File: rtl/udma_i2s_tx_clkgen.sv
// SCK generator: divides clk_i by max(div_i,1) per SCK phase and flags
// the ticks that drive SCK from 1 to 0.
module udma_i2s_tx_clkgen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 sck_o,
  output logic                 fall_tick_o
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic                 r_sck;
  logic                 w_tick;

  assign w_div_eff = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
  assign w_tick    = en_i & (r_cnt == (r_div - DIV_WIDTH'(1)));

  // The divisor is captured only while disabled or when the count wraps,
  // so a config change never produces a truncated SCK phase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!en_i) begin
      r_cnt <= '0;
      r_div <= w_div_eff;
      r_sck <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_div <= w_div_eff;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
    end
  end

  assign sck_o       = r_sck & en_i;
  assign fall_tick_o = w_tick & r_sck;

endmodule

// File: rtl/udma_i2s_tx_serializer.sv
// I2S transmit serializer fed by a uDMA TX channel through a one-entry buffer.
// Optional macro I2S_TX_LSB_FIRST_EN enables LSB-first slots via cfg_lsb_first_i.
module udma_i2s_tx_serializer
  import udma_i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [DIV_WIDTH-1:0]  cfg_clk_div_i,
  input  logic [4:0]            cfg_bits_word_i,
  input  logic                  cfg_lsb_first_i,
  input  logic [DATA_WIDTH-1:0] data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic                  i2s_sck_o,
  output logic                  i2s_ws_o,
  output logic                  i2s_sd_o,
  output logic                  underrun_o
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     w_active;

  logic                     r_buf_full;
  logic [DATA_WIDTH-1:0]    r_buf;
  logic                     w_accept;
  logic                     w_load;

  logic                     w_sck;
  logic                     w_fall;
  logic                     w_slot_start;
  logic                     w_last_bit;

  logic [MAX_BITS_WORD-1:0] r_word;
  logic [MAX_BITS_WORD-1:0] w_load_word;
  logic [MAX_BITS_WORD-1:0] w_word;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic [BIT_CNT_W-1:0]     r_last_idx;
  logic [BIT_CNT_W-1:0]     w_last_idx;
  logic [BIT_CNT_W-1:0]     w_idx;
  logic                     r_lsb;
  logic                     w_lsb_cfg;
  logic                     w_lsb;
  logic                     r_ws;
  logic                     r_sd;
  logic                     r_underrun;

`ifdef I2S_TX_LSB_FIRST_EN
  assign w_lsb_cfg = cfg_lsb_first_i;
`else
  assign w_lsb_cfg = 1'b0 & cfg_lsb_first_i;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cfg_en_i)  w_state_next = RUN;
      RUN:     if (!cfg_en_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Dropping the enable silences the outputs in the same cycle.
  assign w_active = cfg_en_i & (r_state == RUN);

  udma_i2s_tx_clkgen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (w_active),
    .div_i       (cfg_clk_div_i),
    .sck_o       (w_sck),
    .fall_tick_o (w_fall)
  );

  // Ready is also held low while reset is asserted so every output is quiet.
  assign data_tx_ready_o = cfg_en_i & rstn_i & ~r_buf_full;
  assign w_accept        = data_tx_valid_i & data_tx_ready_o;
  assign w_slot_start    = (r_bit_cnt == '0);
  assign w_load          = w_fall & w_slot_start & r_buf_full;

  // NOTE: the buffer payload is reset along with its flag; it is a single
  // word, not a memory array, so there is no reason to leave it undefined.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (!cfg_en_i) begin
      r_buf_full <= 1'b0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= data_tx_i;
    end
  end

  // Width, order and word are taken live at slot start and held afterwards.
  assign w_load_word = r_buf_full ? MAX_BITS_WORD'(r_buf) : '0;
  assign w_word      = w_slot_start ? w_load_word     : r_word;
  assign w_last_idx  = w_slot_start ? cfg_bits_word_i : r_last_idx;
  assign w_lsb       = w_slot_start ? w_lsb_cfg       : r_lsb;
  assign w_idx       = slot_bit_idx(w_lsb, w_last_idx, r_bit_cnt);
  assign w_last_bit  = (r_bit_cnt == w_last_idx);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_word     <= '0;
      r_bit_cnt  <= '0;
      r_last_idx <= '0;
      r_lsb      <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!w_active) begin
      r_word     <= '0;
      r_bit_cnt  <= '0;
      r_last_idx <= '0;
      r_lsb      <= 1'b0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_fall & w_slot_start & ~r_buf_full;
      if (w_fall) begin
        r_sd <= w_word[w_idx];
        if (w_slot_start) begin
          r_word     <= w_load_word;
          r_last_idx <= cfg_bits_word_i;
          r_lsb      <= w_lsb_cfg;
        end
        // WS flips together with the last bit: the one-bit I2S delay.
        if (w_last_bit) begin
          r_bit_cnt <= '0;
          r_ws      <= ~r_ws;
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign i2s_sck_o  = w_sck;
  assign i2s_ws_o   = r_ws & w_active;
  assign i2s_sd_o   = r_sd & w_active;
  assign underrun_o = r_underrun & w_active;

endmodule

// File: tb/tb_udma_i2s_tx_serializer.sv
// Self-checking bench for udma_i2s_tx_serializer: table-driven single-slot
// vectors plus hand-written multi-slot, enable-drop and reset sequences.
module tb_udma_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [15:0] div;
  logic [4:0]  bits;
  logic        lsb;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        und;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent capture() call.
  logic [63:0] cap_sd_stream;
  logic [63:0] cap_ws_stream;
  logic        cap_first_sd;
  logic        cap_first_ws;
  int          cap_rises;
  int          cap_period;
  int          cap_und_high;
  int          cap_und_rises;

`ifdef I2S_TX_LSB_FIRST_EN
  localparam logic [63:0] LSB_EXP_A = 64'h80;
  localparam logic [63:0] LSB_EXP_B = 64'h0D;
`else
  localparam logic [63:0] LSB_EXP_A = 64'h01;
  localparam logic [63:0] LSB_EXP_B = 64'h16;
`endif

  typedef struct {
    string       name;
    logic [15:0] div;
    logic [4:0]  bits;
    logic        lsb;
    logic [31:0] data;
    int          exp_period;
    logic [63:0] exp_sd;
    logic [63:0] exp_ws;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  udma_i2s_tx_serializer dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (en),
    .cfg_clk_div_i   (div),
    .cfg_bits_word_i (bits),
    .cfg_lsb_first_i (lsb),
    .data_tx_i       (data),
    .data_tx_valid_i (valid),
    .data_tx_ready_o (ready),
    .i2s_sck_o       (sck),
    .i2s_ws_o        (ws),
    .i2s_sd_o        (sd),
    .underrun_o      (und)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one sample and returns on the negedge after the handshake.
  task automatic send(input logic [31:0] d);
    int n;
    n     = 0;
    data  = d;
    valid = 1'b1;
    #1;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(ready), 64'h1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Records sd/ws at each SCK rising edge; the first rise precedes any data.
  task automatic capture(input int n_rises);
    logic prev_sck;
    logic prev_und;
    int   rises;
    int   first_cyc;
    int   c;
    rises         = 0;
    first_cyc     = 0;
    c             = 0;
    cap_sd_stream = '0;
    cap_ws_stream = '0;
    cap_first_sd  = 1'b0;
    cap_first_ws  = 1'b0;
    cap_period    = -1;
    cap_und_high  = 0;
    cap_und_rises = 0;
    prev_sck      = sck;
    prev_und      = und;
    while (rises < n_rises && c < 4000) begin
      @(negedge clk);
      c++;
      if (und) cap_und_high++;
      if (und && !prev_und) cap_und_rises++;
      if (sck && !prev_sck) begin
        if (rises == 0) begin
          cap_first_sd = sd;
          cap_first_ws = ws;
          first_cyc    = c;
        end else begin
          cap_sd_stream = {cap_sd_stream[62:0], sd};
          cap_ws_stream = {cap_ws_stream[62:0], ws};
          if (rises == 1) cap_period = c - first_cyc;
        end
        rises++;
      end
      prev_sck = sck;
      prev_und = und;
    end
    cap_rises = rises;
  endtask

  task automatic disable_and_config(input logic [15:0] d, input logic [4:0] b, input logic l);
    en    = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    div  = d;
    bits = b;
    lsb  = l;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"msb16_div2",   16'd2, 5'd15, 1'b0, 32'h0000A5A5, 4, 64'hA5A5,     64'h1};
    vecs[1] = '{"msb8_hi_ign",  16'd1, 5'd7,  1'b0, 32'h123456C3, 2, 64'hC3,       64'h1};
    vecs[2] = '{"div0",         16'd0, 5'd7,  1'b0, 32'h00000081, 2, 64'h81,       64'h1};
    vecs[3] = '{"msb32_div3",   16'd3, 5'd31, 1'b0, 32'hDEADBEEF, 6, 64'hDEADBEEF, 64'h1};
    vecs[4] = '{"one_bit_slot", 16'd1, 5'd0,  1'b0, 32'h00000003, 2, 64'h1,        64'h1};
    vecs[5] = '{"lsb8_01",      16'd1, 5'd7,  1'b1, 32'h00000001, 2, LSB_EXP_A,    64'h1};
    vecs[6] = '{"lsb5_16",      16'd2, 5'd4,  1'b1, 32'h00000016, 4, LSB_EXP_B,    64'h1};

    // Reset with enable and valid held high: every output must be low.
    rstn  = 1'b0;
    en    = 1'b1;
    valid = 1'b1;
    data  = 32'hFFFFFFFF;
    div   = 16'd1;
    bits  = 5'd7;
    lsb   = 1'b0;
    #2;
    check("reset_outputs_t0", {59'd0, ready, sck, ws, sd, und}, 64'h0);
    repeat (4) @(negedge clk);
    check("reset_outputs_held", {59'd0, ready, sck, ws, sd, und}, 64'h0);
    en    = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_outputs", {59'd0, ready, sck, ws, sd, und}, 64'h0);

    // Table-driven single-slot vectors, each starting from a fresh enable.
    for (int i = 0; i < 7; i++) begin
      vec_t v;
      v = vecs[i];
      disable_and_config(v.div, v.bits, v.lsb);
      en = 1'b1;
      fork
        send(v.data);
        capture(int'(v.bits) + 2);
      join
      check($sformatf("%s_rises", v.name), 64'(cap_rises), 64'(int'(v.bits) + 2));
      check($sformatf("%s_period", v.name), 64'(cap_period), 64'(v.exp_period));
      check($sformatf("%s_first", v.name), {62'd0, cap_first_ws, cap_first_sd}, 64'h0);
      check($sformatf("%s_sd", v.name), cap_sd_stream, v.exp_sd);
      check($sformatf("%s_ws", v.name), cap_ws_stream, v.exp_ws);
      check($sformatf("%s_underrun", v.name), 64'(cap_und_rises), 64'h0);
    end

    // Two back-to-back slots: left A5A5 then right 0F0F, no gap.
    disable_and_config(16'd2, 5'd15, 1'b0);
    en = 1'b1;
    fork
      begin
        send(32'h0000A5A5);
        send(32'h00000F0F);
      end
      capture(33);
    join
    check("lr_rises", 64'(cap_rises), 64'd33);
    check("lr_period", 64'(cap_period), 64'd4);
    check("lr_sd", cap_sd_stream, 64'hA5A50F0F);
    check("lr_ws", cap_ws_stream, 64'h0001FFFE);
    check("lr_underrun", 64'(cap_und_rises), 64'h0);

    // No samples: zeros out, one single-cycle underrun per slot, WS alternates.
    disable_and_config(16'd1, 5'd3, 1'b0);
    en = 1'b1;
    capture(13);
    check("ur_rises", 64'(cap_rises), 64'd13);
    check("ur_sd", cap_sd_stream, 64'h0);
    check("ur_ws", cap_ws_stream, 64'h1E1);
    check("ur_pulses", 64'(cap_und_rises), 64'd3);
    check("ur_high_cycles", 64'(cap_und_high), 64'd3);

    // Enable dropped in the middle of a right slot with SCK high.
    disable_and_config(16'd2, 5'd15, 1'b0);
    en = 1'b1;
    send(32'h00001234);
    send(32'h0000FFFF);
    for (int n = 0; n < 300 && !(ws && sck); n++) @(negedge clk);
    check("drop_pre_state", {62'd0, sck, ws}, 64'h3);
    en = 1'b0;
    #1;
    check("drop_outputs", {59'd0, ready, sck, ws, sd, und}, 64'h0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    fork
      send(32'h0000C000);
      capture(17);
    join
    check("reen_first", {62'd0, cap_first_ws, cap_first_sd}, 64'h0);
    check("reen_sd", cap_sd_stream, 64'hC000);
    check("reen_ws", cap_ws_stream, 64'h1);

    // Asynchronous reset mid-slot with enable held, then restart on left.
    disable_and_config(16'd1, 5'd7, 1'b0);
    en = 1'b1;
    send(32'h000000FF);
    for (int n = 0; n < 100 && !(sck && sd); n++) @(negedge clk);
    check("rst_pre_state", {62'd0, sck, sd}, 64'h3);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_outputs", {59'd0, ready, sck, ws, sd, und}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    fork
      send(32'h0000005A);
      capture(9);
    join
    check("rst_restart_first", {62'd0, cap_first_ws, cap_first_sd}, 64'h0);
    check("rst_restart_sd", cap_sd_stream, 64'h5A);
    check("rst_restart_ws", cap_ws_stream, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
